imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the fetch unit reads.
- Accepts a byte stream over a valid/ready handshake, carrying a 16-bit word-count header followed by little-endian 32-bit instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses from 0.
- Holds the processor core in reset (cpu_hold) until the image is fully loaded.

---
 rtl/loader_pkg.sv | 29 ++
 rtl/imem_loader_if.sv | 28 ++
 rtl/word_assembler.sv | 63 ++++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_t         : loader FSM states
//   HDR_BYTES       : bytes in the little-endian word-count header
//   BYTES_PER_WORD  : bytes per assembled instruction word
//   is_accepting()  : states in which the byte stream is accepted
package loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = HDR_BYTES * BYTE_W;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Header and payload states take bytes; everything else stalls the stream.
  function automatic logic is_accepting(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   byte_data/byte_valid/byte_ready : valid/ready byte stream
//   mem_we/mem_addr/mem_wdata       : single-port memory write
// master: stream source / memory side, slave: the loader.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
);

  logic [BYTE_W-1:0]     byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Packs stream bytes into little-endian words (first byte -> bits [7:0]).
//   clk, reset     : clock, synchronous active-high reset
//   clear          : drop any partial word and restart at lane 0
//   byte_in/byte_en: byte to store in the current lane
//   word_out       : last completed word, held until the next one completes
//   word_complete  : one-cycle pulse the cycle after the last lane is filled
//   last_lane_c    : current lane is the final lane of a word
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_complete,
  output logic              last_lane_c
);

  logic [LANE_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] lanes_q, lanes_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              complete_q, complete_d;

  assign last_lane_c   = (idx_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_out      = word_q;
  assign word_complete = complete_q;

  // Lane fill; the finished word is snapshotted so lanes can refill immediately.
  always_comb begin
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    word_d     = word_q;
    complete_d = 1'b0;
    if (clear) begin
      idx_d   = '0;
      lanes_d = '0;
    end else if (byte_en) begin
      lanes_d[idx_q*BYTE_W +: BYTE_W] = byte_in;
      idx_d = idx_q + LANE_W'(1);
      if (last_lane_c) begin
        word_d     = lanes_d;
        complete_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      lanes_q    <= '0;
      word_q     <= '0;
      complete_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      lanes_q    <= lanes_d;
      word_q     <= word_d;
      complete_q <= complete_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads an instruction image from a byte stream into instruction memory and
// keeps the core in reset until the image is complete.
//   clk, reset   : clock, synchronous active-high reset
//   start        : pulse to begin a load from IDLE, DONE or ERROR
//   bus          : byte stream in, memory write port out (imem_loader_if.slave)
//   cpu_hold     : processor reset, released only after a successful load
//   done, error  : load finished / header count larger than memory
//   words_loaded : words written during the current load
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
  localparam int unsigned WL_W  = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WL_W-1:0]       words_loaded_q, words_loaded_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  hold_q, hold_d;

  logic                  byte_ready_c;
  logic                  xfer_c;
  logic                  start_take_c;
  logic                  asm_en_c;
  logic                  last_lane_c;
  logic                  word_last_c;
  logic                  final_word_c;
  logic [CNT_W-1:0]      hdr_count_c;
  logic [WORD_W-1:0]     asm_word;
  logic                  asm_complete;

  assign byte_ready_c = is_accepting(state_q);
  assign xfer_c       = bus.byte_valid & byte_ready_c;
  assign start_take_c = start & ~byte_ready_c;
  assign asm_en_c     = xfer_c & (state_q == DATA);
  assign word_last_c  = asm_en_c & last_lane_c;
  assign final_word_c = (32'(words_loaded_q) + 32'd1) == 32'(count_q);
  assign hdr_count_c  = {bus.byte_data, count_q[BYTE_W-1:0]};

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_take_c),
    .byte_in       (bus.byte_data),
    .byte_en       (asm_en_c),
    .word_out      (asm_word),
    .word_complete (asm_complete),
    .last_lane_c   (last_lane_c)
  );

  // State register and datapath/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      words_loaded_q <= '0;
      mem_addr_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      hold_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      words_loaded_q <= words_loaded_d;
      mem_addr_q     <= mem_addr_d;
      done_q         <= done_d;
      error_q        <= error_d;
      hold_q         <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = LEN_LO;
      LEN_LO:            if (xfer_c) state_d = LEN_HI;
      LEN_HI: begin
        if (xfer_c) begin
          if (hdr_count_c == '0)               state_d = DONE;
          else if (32'(hdr_count_c) > DEPTH)   state_d = ERROR;
          else                                 state_d = DATA;
        end
      end
      DATA:              if (word_last_c && final_word_c) state_d = DONE;
      default:           state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Status follows state one cycle late, so
  // the last memory write is always visible before cpu_hold drops.
  always_comb begin
    count_d        = count_q;
    words_loaded_d = words_loaded_q;
    mem_addr_d     = mem_addr_q;
    done_d         = (state_q == DONE)  && !start;
    error_d        = (state_q == ERROR) && !start;
    hold_d         = !done_d;

    if (start_take_c) words_loaded_d = '0;

    if (xfer_c && (state_q == LEN_LO)) count_d = {count_q[CNT_W-1:BYTE_W], bus.byte_data};
    if (xfer_c && (state_q == LEN_HI)) count_d = hdr_count_c;

    // Address is the pre-increment count, so a full image ends at DEPTH-1.
    if (word_last_c) begin
      mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
      words_loaded_d = words_loaded_q + WL_W'(1);
    end
  end

  assign bus.byte_ready = byte_ready_c;
  assign bus.mem_we     = asm_complete;
  assign bus.mem_wdata  = asm_word;
  assign bus.mem_addr   = mem_addr_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned AW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [AW:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  img[$];
  logic [31:0] exp_w[$];

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every mem_we must match the oldest expected write and arrive on time.
  always @(negedge clk) begin
    if (!reset && bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        chk("write_data", bus.mem_wdata, mon_e.data);
        chk("write_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: byte_ready still %b after %0d cycles", bus.byte_ready, n);
    end
  endtask

  // Sends img; gap_mode 1 gives valid pattern 1,0,0,1,...; start_at raises start with that byte.
  task automatic send_image(input int gap_mode, input int start_at);
    exp_t e;
    for (int i = 0; i < img.size(); i++) begin
      if (gap_mode == 1 && (i % 2) == 1) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hFF;
        tick();
        tick();
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = img[i];
      wait_ready();
      start = (i == start_at);
      if (i >= 2 && ((i - 2) % 4) == 3) begin
        e.addr = (i - 2) / 4;
        e.data = exp_w[(i - 2) / 4];
        e.due  = cyc + 1;
        sb.push_back(e);
      end
      tick();
      start = 1'b0;
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  // Called at t+1 after the last byte: status must still show loading, then flip.
  task automatic expect_done(input int nwords);
    chk("done_lag", 32'(done), 32'd0);
    chk("hold_lag", 32'(cpu_hold), 32'd1);
    tick();
    chk("done", 32'(done), 32'd1);
    chk("cpu_hold_release", 32'(cpu_hold), 32'd0);
    chk("error_clear", 32'(error), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'(nwords));
    chk("ready_in_done", 32'(bus.byte_ready), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic load_nominal();
    img   = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    exp_w = '{32'h00A00513, 32'h00100593};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Nominal load, back-to-back bytes.
    load_nominal();
    pulse_start();
    chk("ready_after_start", 32'(bus.byte_ready), 32'd1);
    send_image(0, -1);
    expect_done(2);

    // Same image with valid gaps; start from DONE clears status next cycle.
    pulse_start();
    chk("reload_done_clear", 32'(done), 32'd0);
    chk("reload_hold_set", 32'(cpu_hold), 32'd1);
    chk("reload_wl_clear", 32'(words_loaded), 32'd0);
    send_image(1, -1);
    expect_done(2);

    // Zero-length header.
    img = '{8'h00, 8'h00};
    exp_w = {};
    pulse_start();
    send_image(0, -1);
    expect_done(0);

    // Header one larger than memory.
    img = '{8'h05, 8'h00};
    pulse_start();
    send_image(0, -1);
    chk("err_lag", 32'(error), 32'd0);
    tick();
    chk("err_set", 32'(error), 32'd1);
    chk("err_hold", 32'(cpu_hold), 32'd1);
    chk("err_done", 32'(done), 32'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      chk("err_ready_low", 32'(bus.byte_ready), 32'd0);
      tick();
    end
    bus.byte_valid = 1'b0;
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_words", 32'(words_loaded), 32'd0);

    // Exact fit: DEPTH words, started from ERROR.
    pulse_start();
    chk("err_start_clear", 32'(error), 32'd0);
    img = '{8'h04, 8'h00,
            8'h01, 8'h00, 8'h00, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'h78, 8'h56, 8'h34, 8'h12,
            8'h00, 8'hFF, 8'h00, 8'hFF};
    exp_w = '{32'h00000001, 32'hDEADBEEF, 32'h12345678, 32'hFF00FF00};
    send_image(0, -1);
    expect_done(4);

    // Reset after two data bytes of the first word, then a clean reload.
    pulse_start();
    img = '{8'h02, 8'h00, 8'h13, 8'h05};
    exp_w = {};
    send_image(0, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    tick();
    chk("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);
    load_nominal();
    pulse_start();
    send_image(0, -1);
    expect_done(2);

    // start raised during DATA is ignored.
    pulse_start();
    send_image(0, 5);
    expect_done(2);

    // start and a byte together in DONE: start wins, byte is not taken.
    start          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    chk("collide_ready", 32'(bus.byte_ready), 32'd0);
    tick();
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    chk("collide_done_clear", 32'(done), 32'd0);
    chk("collide_hold", 32'(cpu_hold), 32'd1);
    img   = '{8'h01, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01};
    exp_w = '{32'h01234567};
    send_image(0, -1);
    expect_done(1);

    tick();
    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
